// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers returned
// words with their PCs, and handles decode back-pressure and PCSrc redirects.
module fetch_stage #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int unsigned        BUF_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  pc_target,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [7:0]         if_op
);
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CW-1:0]      count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]      iwr_q, iwr_d, ird_q, ird_d;

  logic [INSTR_W-1:0] ibuf_q [BUF_DEPTH];
  logic [ADDR_W-1:0]  bpc_q  [BUF_DEPTH];
  logic [ADDR_W-1:0]  ipc_q  [BUF_DEPTH];

  logic               rsp_fire, rsp_push, req_fire, pop;
  logic [CW-1:0]      inflight_rem;
  logic [CW:0]        occupancy;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A response arriving during a redirect or while draining stale requests is never buffered.
  always_comb begin
    rsp_fire       = imem_rsp_valid;
    rsp_push       = rsp_fire && (drop_q == '0) && !pc_src;
    inflight_rem   = inflight_q - CW'(rsp_fire);
    occupancy      = {1'b0, count_q} + {1'b0, inflight_q};
    imem_req_valid = (state_q != BOOT) && !pc_src && (occupancy < (CW+1)'(BUF_DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    if_valid       = (count_q != '0);
    pop            = if_valid && !id_stall && !pc_src;
    if_instr       = if_valid ? ibuf_q[head_q] : '0;
    if_pc          = if_valid ? bpc_q[head_q] : '0;
    if_op          = if_instr[INSTR_W-1 -: 8];
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_rem + CW'(req_fire);
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    iwr_d      = req_fire ? next_ptr(iwr_q) : iwr_q;
    ird_d      = rsp_fire ? next_ptr(ird_q) : ird_q;

    if (pc_src) begin
      pc_d    = pc_target;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      drop_d  = inflight_rem;
      state_d = (state_q != BOOT && inflight_rem != '0) ? FLUSH : FETCH;
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_W'(4);
      if (rsp_fire && drop_q != '0) drop_d = drop_q - 1'b1;
      count_d = count_q + CW'(rsp_push) - CW'(pop);
      if (rsp_push) tail_d = next_ptr(tail_q);
      if (pop) head_d = next_ptr(head_q);
      case (state_q)
        BOOT:    state_d = FETCH;
        FLUSH:   if (drop_d == '0) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      iwr_q      <= '0;
      ird_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      iwr_q      <= iwr_d;
      ird_q      <= ird_d;
    end
  end

  // Issued-address FIFO pairs each in-order response with the PC it was fetched from.
  always_ff @(posedge clock) begin
    if (req_fire) ipc_q[iwr_q] <= pc_q;
    if (rsp_push) begin
      ibuf_q[tail_q] <= imem_rsp_data;
      bpc_q[tail_q]  <= ipc_q[ird_q];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (rsp_fire) assert (inflight_q != '0);
      if (rsp_push) assert (count_q < CW'(BUF_DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, back-pressure, memory stall,
// redirect with stale-response discard, and PC wrap on a second instance.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset, reset2;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, pc_target, if_instr, if_pc;
  logic        pc_src, id_stall, if_valid;
  logic [7:0]  if_op;
  logic        imem_req_valid2, imem_rsp_valid2, if_valid2;
  logic [31:0] imem_req_addr2, imem_rsp_data2, if_instr2, if_pc2;
  logic [7:0]  if_op2;
  logic        ready2 = 1'b1, pc_src2 = 1'b0, stall2 = 1'b0;
  logic [31:0] target2 = 32'h0;

  int          n_checks = 0, n_fail = 0, cyc = 0, lat = 1;
  logic [31:0] pa[$], pa2[$];
  int          pd[$], pd2[$];
  logic [31:0] lpc[$], lpc2[$];
  logic [7:0]  lop[$], lop2[$];

  logic [31:0] exp_stream_pc [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
  logic [7:0]  exp_stream_op [6] = '{8'hC3, 8'hC2, 8'hC1, 8'hC0, 8'hC7, 8'hC6};
  logic [31:0] exp_wrap_pc   [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
  logic [7:0]  exp_wrap_op   [3] = '{8'h3D, 8'h3C, 8'hC3};

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc_src(pc_src), .pc_target(pc_target),
    .id_stall(id_stall), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_op(if_op)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clock(clock), .reset(reset2),
    .imem_req_valid(imem_req_valid2), .imem_req_addr(imem_req_addr2),
    .imem_req_ready(ready2), .imem_rsp_valid(imem_rsp_valid2),
    .imem_rsp_data(imem_rsp_data2), .pc_src(pc_src2), .pc_target(target2),
    .id_stall(stall2), .if_valid(if_valid2), .if_instr(if_instr2),
    .if_pc(if_pc2), .if_op(if_op2)
  );

  // Memory contents: opcode byte = addr[9:2]^0xC3, low 24 bits = addr[23:0].
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[9:2] ^ 8'hC3, a[23:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic        hs, rs, hs2, rs2;
    logic [31:0] a, a2;
    hs  = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rs  = imem_rsp_valid;
    hs2 = imem_req_valid2 && ready2;
    a2  = imem_req_addr2;
    rs2 = imem_rsp_valid2;
    if (if_valid && !id_stall && !pc_src) begin
      lpc.push_back(if_pc);
      lop.push_back(if_op);
    end
    if (if_valid2 && lpc2.size() < 8) begin
      lpc2.push_back(if_pc2);
      lop2.push_back(if_op2);
    end
    @(posedge clock); #1;
    cyc++;
    if (rs && pa.size() > 0) begin void'(pa.pop_front()); void'(pd.pop_front()); end
    if (hs) begin pa.push_back(a); pd.push_back(cyc + lat - 1); end
    if (pa.size() > 0 && pd[0] <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mdata(pa[0]);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    end
    if (rs2 && pa2.size() > 0) begin void'(pa2.pop_front()); void'(pd2.pop_front()); end
    if (hs2) begin pa2.push_back(a2); pd2.push_back(cyc); end
    if (pa2.size() > 0 && pd2[0] <= cyc) begin
      imem_rsp_valid2 = 1'b1; imem_rsp_data2 = mdata(pa2[0]);
    end else begin
      imem_rsp_valid2 = 1'b0; imem_rsp_data2 = '0;
    end
    @(negedge clock); #1;
  endtask

  // Leaves the bench in the BOOT cycle (c0) with an empty memory pipeline.
  task automatic do_reset(input int l);
    reset = 1'b1; pc_src = 1'b0; id_stall = 1'b0; imem_req_ready = 1'b1; pc_target = '0;
    tick();
    pa.delete(); pd.delete(); lpc.delete(); lop.delete();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    lat = l; cyc = 0;
    reset = 1'b0; #1;
  endtask

  task automatic check_log(input string tag, input int n, input logic [31:0] first);
    logic [31:0] v;
    check({tag, "_count_ok"}, 32'(lpc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      v = (i < lpc.size()) ? lpc[i] : 32'hDEAD_BEEF;
      check($sformatf("%s_pc%0d", tag, i), v, first + 32'(4 * i));
    end
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; reset2 = 1'b1; pc_src = 1'b0; id_stall = 1'b0; pc_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_valid2 = 1'b0; imem_rsp_data2 = '0;
    @(negedge clock); #1;
    check("rst_if_valid", if_valid, 0);
    reset2 = 1'b0;

    // Streaming fill: accept at E2, first word visible in c3.
    do_reset(1);
    check("boot_idle", imem_req_valid, 0);
    tick();
    check("first_req_addr", imem_req_addr, 32'h0);
    tick();
    check("fill_c2_empty", if_valid, 0);
    tick();
    check("c3_valid", if_valid, 1);
    check("c3_pc", if_pc, 32'h0);
    check("c3_instr", if_instr, 32'hC300_0000);
    check("c3_op", if_op, 8'hC3);
    tick();
    check("c4_pc", if_pc, 32'h4);
    check("c4_instr", if_instr, 32'hC200_0004);

    // Reset mid-fetch: outputs clear immediately, then one idle cycle.
    reset = 1'b1; #1;
    check("rst_async_req_valid", imem_req_valid, 0);
    check("rst_async_if_valid", if_valid, 0);
    check("rst_async_if_instr", if_instr, 0);
    check("rst_async_if_pc", if_pc, 0);
    check("rst_async_if_op", if_op, 0);
    do_reset(1);
    check("rst_idle_cycle", imem_req_valid, 0);
    tick();
    check("rst_req_valid", imem_req_valid, 1);
    check("rst_req_addr", imem_req_addr, 32'h0);
    repeat (13) tick();
    check_log("stream", 6, 32'h0);
    for (int i = 0; i < 6; i++) begin
      v = (i < lop.size()) ? 32'(lop[i]) : 32'hDEAD_BEEF;
      check($sformatf("stream_op%0d", i), v, 32'(exp_stream_op[i]));
    end

    // Back-pressure: decode stalled c0..c4.
    do_reset(1);
    id_stall = 1'b1; #1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k >= 3) check($sformatf("bp_req_stop_c%0d", k), imem_req_valid, 0);
    end
    check("bp_head_held", if_pc, 32'h0);
    tick();
    id_stall = 1'b0; #1;
    check("bp_full_no_req", imem_req_valid, 0);
    check("bp_resume_pc", if_pc, 32'h0);
    repeat (10) tick();
    check_log("bp", 5, 32'h0);

    // Memory stall at pc=0x8 for c4..c6.
    do_reset(1);
    repeat (4) tick();
    imem_req_ready = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mstall_valid%0d", k), imem_req_valid, 1);
      check($sformatf("mstall_addr%0d", k), imem_req_addr, 32'h8);
      tick();
    end
    imem_req_ready = 1'b1; #1;
    check("mstall_accept_addr", imem_req_addr, 32'h8);
    tick();
    check("mstall_next_addr", imem_req_addr, 32'hC);
    check("mstall_next_valid", imem_req_valid, 1);
    repeat (8) tick();
    check_log("mstall", 5, 32'h0);

    // Redirect with two requests outstanding (3-cycle memory).
    do_reset(3);
    repeat (4) tick();
    pc_src = 1'b1; pc_target = 32'h100; #1;
    check("redir_no_req", imem_req_valid, 0);
    tick();
    pc_src = 1'b0; pc_target = '0; #1;
    check("redir_target_valid", imem_req_valid, 1);
    check("redir_target_addr", imem_req_addr, 32'h100);
    check("redir_c5_empty", if_valid, 0);
    tick();
    check("redir_c6_addr", imem_req_addr, 32'h104);
    check("redir_c6_empty", if_valid, 0);
    tick();
    check("redir_c7_empty", if_valid, 0);
    tick();
    check("redir_c8_empty", if_valid, 0);
    tick();
    check("redir_c9_valid", if_valid, 1);
    check("redir_c9_pc", if_pc, 32'h100);
    check("redir_c9_op", if_op, 8'h83);
    check("redir_c9_instr", if_instr, 32'h8300_0100);
    repeat (3) tick();
    check_log("redir", 2, 32'h100);

    // Wrap on the RESET_PC=0xFFFF_FFF8 instance, running since time zero.
    check("wrap_count_ok", 32'(lpc2.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      v = (i < lpc2.size()) ? lpc2[i] : 32'hDEAD_BEEF;
      check($sformatf("wrap_pc%0d", i), v, exp_wrap_pc[i]);
      v = (i < lop2.size()) ? 32'(lop2[i]) : 32'hDEAD_BEEF;
      check($sformatf("wrap_op%0d", i), v, 32'(exp_wrap_op[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
